// File: rtl/pll_sd.sv
// pll_sd: counter-based clock divider pair with phase offset and lock delay.
// Optional PLL_SD_OUTPUT_GATE_EN holds both divided clocks low until lock.
module pll_sd #(
    parameter int ODIV0       = 2,
    parameter int ODIV1       = 2,
    parameter int PHASE1      = 1,
    parameter int LOCK_CYCLES = 64
) (
    input  logic clkin1,
    input  logic pll_rst,
    output logic clkout0,
    output logic clkout1,
    output logic pll_lock
);

    localparam logic [9:0]  CNT0_MAX = 10'(ODIV0 - 1);
    localparam logic [9:0]  CNT1_MAX = 10'(ODIV1 - 1);
    localparam logic [9:0]  HALF0    = 10'(ODIV0 / 2);
    localparam logic [9:0]  HALF1    = 10'(ODIV1 / 2);
    localparam logic [9:0]  CNT1_RST = 10'((ODIV1 - PHASE1) % ODIV1);
    localparam logic [15:0] LOCK_MAX = 16'(LOCK_CYCLES - 1);

    logic [9:0]  cnt0;
    logic [9:0]  cnt1;
    logic [15:0] lock_cnt;
    logic        lock_nxt;
    logic        gate;

    assign lock_nxt = pll_lock | (lock_cnt == LOCK_MAX);

`ifdef PLL_SD_OUTPUT_GATE_EN
    // Gate on the next lock value so outputs start in the cycle lock shows.
    assign gate = lock_nxt;
`else
    assign gate = 1'b1;
`endif

    always_ff @(posedge clkin1) begin
        if (pll_rst) begin
            cnt0     <= '0;
            cnt1     <= CNT1_RST;
            lock_cnt <= '0;
            clkout0  <= 1'b0;
            clkout1  <= 1'b0;
            pll_lock <= 1'b0;
        end else begin
            cnt0     <= (cnt0 == CNT0_MAX) ? 10'd0 : cnt0 + 10'd1;
            cnt1     <= (cnt1 == CNT1_MAX) ? 10'd0 : cnt1 + 10'd1;
            clkout0  <= gate & (cnt0 < HALF0);
            clkout1  <= gate & (cnt1 < HALF1);
            lock_cnt <= pll_lock ? lock_cnt : lock_cnt + 16'd1;
            pll_lock <= lock_nxt;
        end
    end

endmodule

// File: tb/tb_pll_sd.sv
// tb_pll_sd: default and odd-divider instances checked against an
// edge-count reference model, a hand table and reset/lock sequences.
module tb_pll_sd;

    logic clk_tb = 1'b0;
    logic pll_rst = 1'b1;
    logic a_c0, a_c1, a_lk;
    logic b_c0, b_c1, b_lk;

    int n_cmp = 0;
    int n_bad = 0;
    int k = 0;
    int rises = 0;
    logic prev_lk = 1'b0;

    always #10 clk_tb = ~clk_tb;

    pll_sd u_dut (
        .clkin1  (clk_tb),
        .pll_rst (pll_rst),
        .clkout0 (a_c0),
        .clkout1 (a_c1),
        .pll_lock(a_lk)
    );

    pll_sd #(
        .ODIV0      (5),
        .ODIV1      (4),
        .PHASE1     (0),
        .LOCK_CYCLES(7)
    ) u_alt (
        .clkin1  (clk_tb),
        .pll_rst (pll_rst),
        .clkout0 (b_c0),
        .clkout1 (b_c1),
        .pll_lock(b_lk)
    );

    typedef struct {
        logic       rst;
        logic [2:0] exp_a;
        logic [2:0] exp_b;
    } vec_t;

    vec_t tbl[8];

    // Outputs after edge k since release: {clkout0, clkout1, pll_lock}.
    function automatic logic [2:0] model(int kk, int od0, int od1,
                                         int ph, int lk);
        int p0, p1;
        if (kk == 0) return 3'b000;
        p0 = (kk - 1) % od0;
        p1 = (((kk - 1 - ph) % od1) + od1) % od1;
        return {p0 < od0 / 2, p1 < od1 / 2, kk >= lk};
    endfunction

    task automatic check(input string nm, input logic [2:0] act,
                         input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s k=%0d got=%b want=%b", nm, k, act, exp);
        end
    endtask

    task automatic step(input logic r);
        pll_rst = r;
        @(posedge clk_tb);
        #1;
        k = r ? 0 : k + 1;
        if (r) rises = 0;
        else if (a_lk && !prev_lk) rises++;
        prev_lk = a_lk;
    endtask

    task automatic check_model(input string nm);
        check({nm, "_a"}, {a_c0, a_c1, a_lk}, model(k, 2, 2, 1, 64));
        check({nm, "_b"}, {b_c0, b_c1, b_lk}, model(k, 5, 4, 0, 7));
    endtask

    initial begin
        tbl[0] = '{1'b1, 3'b000, 3'b000};
        tbl[1] = '{1'b1, 3'b000, 3'b000};
        tbl[2] = '{1'b0, 3'b100, 3'b110};
        tbl[3] = '{1'b0, 3'b010, 3'b110};
        tbl[4] = '{1'b0, 3'b100, 3'b000};
        tbl[5] = '{1'b0, 3'b010, 3'b000};
        tbl[6] = '{1'b0, 3'b100, 3'b010};
        tbl[7] = '{1'b0, 3'b010, 3'b110};

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].rst);
            check($sformatf("tbl%0d_a", i), {a_c0, a_c1, a_lk}, tbl[i].exp_a);
            check($sformatf("tbl%0d_b", i), {b_c0, b_c1, b_lk}, tbl[i].exp_b);
        end

        // Lock boundary: low through edge 63, high from edge 64.
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 63; i++) step(1'b0);
        check("lock_edge63", {2'b00, a_lk}, 3'b000);
        step(1'b0);
        check("lock_edge64", {2'b00, a_lk}, 3'b001);
        for (int i = 0; i < 300; i++) begin
            step(1'b0);
            check_model("hold");
        end
        check("lock_once", 3'(rises), 3'd1);

        // Reset after lock drops everything on the next edge.
        step(1'b1);
        check("rst_after_lock_a", {a_c0, a_c1, a_lk}, 3'b000);
        check("rst_after_lock_b", {b_c0, b_c1, b_lk}, 3'b000);
        step(1'b1);
        for (int i = 0; i < 63; i++) step(1'b0);
        check("relock_edge63", {2'b00, a_lk}, 3'b000);
        step(1'b0);
        check("relock_edge64", {2'b00, a_lk}, 3'b001);

        // Reset glitch between edges must be ignored.
        #4 pll_rst = 1'b1;
        #3 pll_rst = 1'b0;
        step(1'b0);
        check_model("glitch");
        check("glitch_lock", {2'b00, a_lk}, 3'b001);

        // Randomized reset activity against the edge-count model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 59) == 0);
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
